// File: rtl/fc_layer_seq_if.sv
// rtl/fc_layer_seq_if.sv - frame, coefficient-write and result signals of fc_layer_seq
interface fc_layer_seq_if #(
    parameter int N_IN   = 128,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 32,
    parameter int AW     = 11
) ();
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     valid_in;
    logic [N_IN*DATA_W-1:0]   data_in;
    logic                     in_ready;
    logic                     w_we;
    logic [AW-1:0]            w_addr;
    logic [DATA_W-1:0]        w_data;
    logic                     valid_out;
    logic [DATA_W-1:0]        data_out;
    logic [OW-1:0]            out_idx;
    logic                     frame_done;

    modport master (
        output valid_in, data_in, w_we, w_addr, w_data,
        input  in_ready, valid_out, data_out, out_idx, frame_done
    );

    modport slave (
        input  valid_in, data_in, w_we, w_addr, w_data,
        output in_ready, valid_out, data_out, out_idx, frame_done
    );
endinterface

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - serial fully-connected layer, one signed MAC, optional ReLU via FC_RELU_OUT_EN
module fc_layer_seq #(
    parameter int N_IN   = 128,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int AW     = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    fc_layer_seq_if.slave  bus
);
    localparam int N_COEF    = N_IN*N_OUT + N_OUT;
    localparam int BIAS_BASE = N_IN*N_OUT;
    localparam int IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OW        = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int XW        = $clog2(N_IN*DATA_W);
    localparam int PROD_W    = 2*DATA_W;
    localparam int ACC_W     = PROD_W + $clog2(N_IN);
    localparam int SUM_W     = ACC_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                    state;
    logic [DATA_W-1:0]         coef_mem [N_COEF];
    logic [N_IN*DATA_W-1:0]    act_reg;
    logic [IW-1:0]             i_cnt;
    logic [OW-1:0]             j_cnt;
    logic [AW-1:0]             w_ptr;
    logic signed [ACC_W-1:0]   acc;

    logic [XW-1:0]             x_base;
    logic [AW-1:0]             b_addr;
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [DATA_W-1:0]  w_cur;
    logic signed [DATA_W-1:0]  b_cur;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [SUM_W-1:0]   sum;
    logic [SUM_W-DATA_W:0]     sum_upper;
    logic [DATA_W-1:0]         res;

    // w_ptr walks weight[j][i] linearly, so no j*N_IN multiply is needed
    always_comb begin
        x_base    = XW'(i_cnt * DATA_W);
        b_addr    = AW'(BIAS_BASE) + AW'(j_cnt);
        x_cur     = act_reg[x_base +: DATA_W];
        w_cur     = coef_mem[w_ptr];
        b_cur     = coef_mem[b_addr];
        prod      = x_cur * w_cur;
        acc_shr   = acc >>> FRAC_W;
        sum       = {acc_shr[ACC_W-1], acc_shr}
                  + {{(SUM_W-DATA_W){b_cur[DATA_W-1]}}, b_cur};
        sum_upper = sum[SUM_W-1:DATA_W-1];
        if ((&sum_upper) || !(|sum_upper))
            res = sum[DATA_W-1:0];
        else if (sum[SUM_W-1])
            res = {1'b1, {(DATA_W-1){1'b0}}};
        else
            res = {1'b0, {(DATA_W-1){1'b1}}};
`ifdef FC_RELU_OUT_EN
        if (res[DATA_W-1])
            res = '0;
`endif
    end

    // Coefficients survive reset; writes only land while idle
    always_ff @(posedge clk) begin
        if (bus.w_we && state == S_IDLE && bus.w_addr < AW'(N_COEF))
            coef_mem[bus.w_addr] <= bus.w_data;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.valid_in)
            act_reg <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.in_ready   <= 1'b1;
            bus.valid_out  <= 1'b0;
            bus.data_out   <= '0;
            bus.out_idx    <= '0;
            bus.frame_done <= 1'b0;
            acc            <= '0;
            i_cnt          <= '0;
            j_cnt          <= '0;
            w_ptr          <= '0;
        end else begin
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        acc          <= '0;
                        i_cnt        <= '0;
                        j_cnt        <= '0;
                        w_ptr        <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc   <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    w_ptr <= w_ptr + 1'b1;
                    if (i_cnt == IW'(N_IN-1))
                        state <= S_OUT;
                    else
                        i_cnt <= i_cnt + 1'b1;
                end
                S_OUT: begin
                    bus.data_out  <= res;
                    bus.out_idx   <= j_cnt;
                    bus.valid_out <= 1'b1;
                    acc           <= '0;
                    i_cnt         <= '0;
                    if (j_cnt == OW'(N_OUT-1)) begin
                        bus.frame_done <= 1'b1;
                        bus.in_ready   <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                        state <= S_MAC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - directed vector bench for fc_layer_seq
module tb_fc_layer_seq;
    localparam int N_IN      = 128;
    localparam int N_OUT     = 10;
    localparam int DATA_W    = 32;
    localparam int AW        = 11;
    localparam int BIAS_BASE = N_IN*N_OUT;
    localparam int SPACING   = N_IN + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_layer_seq_if bus ();
    fc_layer_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] x;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] exp_v [N_OUT];
    logic [N_IN*DATA_W-1:0] xvec;

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FC_RELU_OUT_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic load_uniform(input logic [31:0] w, input logic [31:0] b);
        for (int a = 0; a < BIAS_BASE + N_OUT; a++) begin
            bus.w_we   = 1'b1;
            bus.w_addr = AW'(a);
            bus.w_data = (a < BIAS_BASE) ? w : b;
            @(negedge clk);
        end
        bus.w_we = 1'b0;
    endtask

    task automatic fill_x(input logic [31:0] x);
        for (int i = 0; i < N_IN; i++)
            xvec[i*DATA_W +: DATA_W] = x;
    endtask

    task automatic set_exp(input logic [31:0] e);
        for (int j = 0; j < N_OUT; j++)
            exp_v[j] = relu(e);
    endtask

    task automatic start_frame(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.data_in  = xvec;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic collect(input string tag);
        int cyc;
        for (int k = 0; k < N_OUT; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!bus.valid_out && cyc < 300);
            check($sformatf("%s_lat%0d", tag, k), cyc, SPACING);
            if (!bus.valid_out) break;
            check($sformatf("%s_data%0d", tag, k), bus.data_out, exp_v[k]);
            check($sformatf("%s_idx%0d", tag, k), 32'(bus.out_idx), k);
            check($sformatf("%s_done%0d", tag, k), 32'(bus.frame_done), (k == N_OUT-1) ? 1 : 0);
            if (k < N_OUT-1)
                check($sformatf("%s_busy%0d", tag, k), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic quiet(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (bus.valid_out) pulses++;
        end
        check({tag, "_no_valid_out"}, pulses, 0);
    endtask

    initial begin
        vecs[0] = '{32'h00010000, 32'h00000000, 32'h00010000, 32'h00800000};
        vecs[1] = '{32'h00000000, 32'hFFFE0000, 32'h00012345, 32'hFFFE0000};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
        vecs[3] = '{32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000};
        vecs[4] = '{32'h00008000, 32'h00010000, 32'hFFFF8000, 32'hFFE10000};
        vecs[5] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.w_we     = 1'b0;
        bus.w_addr   = '0;
        bus.w_data   = '0;
        xvec         = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            load_uniform(vecs[v].w, vecs[v].b);
            fill_x(vecs[v].x);
            set_exp(vecs[v].e);
            start_frame($sformatf("vec%0d", v));
            collect($sformatf("vec%0d", v));
        end

        // Mid-frame valid_in and coefficient write must both be ignored
        load_uniform(32'h00010000, 32'h0);
        fill_x(32'h00010000);
        set_exp(32'h00800000);
        start_frame("busy");
        fork
            collect("busy");
            begin
                repeat (200) @(negedge clk);
                bus.valid_in = 1'b1;
                bus.w_we     = 1'b1;
                bus.w_addr   = AW'(9*N_IN);
                bus.w_data   = 32'h7FFFFFFF;
                @(negedge clk);
                bus.valid_in = 1'b0;
                bus.w_we     = 1'b0;
            end
        join
        quiet("busy", 300);
        start_frame("busy_rerun");
        collect("busy_rerun");

        // Reset while neuron 4 is being accumulated
        start_frame("rstmid");
        begin
            int n;
            n = 0;
            while (!(bus.valid_out && bus.out_idx == 3) && n < 4*SPACING + 20) begin
                @(negedge clk);
                n++;
            end
            check("rstmid_reach_idx3", 32'(bus.out_idx), 32'd3);
        end
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rstmid_valid_out", 32'(bus.valid_out), 32'd0);
        check("rstmid_data_out", bus.data_out, 32'd0);
        check("rstmid_out_idx", 32'(bus.out_idx), 32'd0);
        rst_n = 1'b1;
        quiet("rstmid", 300);
        start_frame("rstmid_new");
        collect("rstmid_new");

        // Single weight written on the same edge the frame is accepted
        load_uniform(32'h0, 32'hFFFE0000);
        fill_x(32'h0);
        xvec[5*DATA_W +: DATA_W] = 32'hFFFF0000;
        set_exp(32'hFFFE0000);
        exp_v[3] = relu(32'hFFFC0000);
        bus.data_in  = xvec;
        bus.valid_in = 1'b1;
        bus.w_we     = 1'b1;
        bus.w_addr   = AW'(3*N_IN + 5);
        bus.w_data   = 32'h00020000;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.w_we     = 1'b0;
        collect("w35");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
